// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: RV32I branch/jump resolution stage with a 2-bit
// saturating branch history table (BHT).
//
// Decodes B-type, JAL and JALR, evaluates the branch condition, computes the
// target and link addresses, and checks the outcome against the fetch-stage
// direction prediction. All resolve outputs are registered (latency 1).
//
// Handshake: there is no backpressure. An instruction is captured on a
// rising clk edge when valid_in=1 and flush=0 (flush wins). valid_out=1 in
// the following cycle marks the resolve outputs as meaningful. While
// valid_out=0 the data outputs hold their last values and redirect is 0,
// so fetch never restarts from a stale or flushed slot.
//
// Optional build macro: BRU_STATS_EN adds the 32-bit wrapping counters
// stat_cf (captured control-flow instructions) and stat_mispred (captured
// redirects).

module branch_resolve_unit #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] BHT_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            pred_taken_in,
  input  logic            flush,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic            valid_out,
  output logic            is_cf,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]     stat_cf,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_br;
  logic       is_jal;
  logic       is_jalr;
  logic       capture;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  // funct3 010/011 under the branch opcode are reserved and treated as non-CF.
  assign is_br   = (opcode == OP_BRANCH) && (funct3 != 3'b010) && (funct3 != 3'b011);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR) && (funct3 == 3'b000);
  assign capture = valid_in & ~flush;

  // Sign-extended immediates; all address sums below wrap modulo 2^XLEN.
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_i;

  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jal_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;

  assign pc_plus4    = pc + XLEN'(4);
  assign br_target   = pc + imm_b;
  assign jal_target  = pc + imm_j;
  assign jalr_sum    = rs1 + imm_i;
  assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};

  // Branch condition evaluated on the full operand width.
  logic br_cond;
  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond = (rs1 == rs2);
      F3_BNE:  br_cond = (rs1 != rs2);
      F3_BLT:  br_cond = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  br_cond = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: br_cond = (rs1 <  rs2);
      F3_BGEU: br_cond = (rs1 >= rs2);
      default: br_cond = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Resolution
  // ---------------------------------------------------------------------
  logic            res_is_cf;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            res_redirect;
  logic [XLEN-1:0] res_redirect_pc;

  // Outcome, target and mispredict decision for the presented instruction.
  always_comb begin
    res_is_cf       = 1'b0;
    res_taken       = 1'b0;
    res_target      = br_target;
    res_redirect    = 1'b0;
    res_redirect_pc = pc_plus4;
    if (is_br) begin
      res_is_cf       = 1'b1;
      res_taken       = br_cond;
      res_redirect    = br_cond ^ pred_taken_in;
      res_redirect_pc = br_cond ? br_target : pc_plus4;
    end else if (is_jal) begin
      res_is_cf       = 1'b1;
      res_taken       = 1'b1;
      res_target      = jal_target;
      res_redirect    = ~pred_taken_in;
      res_redirect_pc = jal_target;
    end else if (is_jalr) begin
      // No target prediction exists for JALR, so it always redirects.
      res_is_cf       = 1'b1;
      res_taken       = 1'b1;
      res_target      = jalr_target;
      res_redirect    = 1'b1;
      res_redirect_pc = jalr_target;
    end
  end

  // Resolve output register: data holds between captures, redirect pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out   <= 1'b0;
      is_cf       <= 1'b0;
      taken       <= 1'b0;
      target      <= '0;
      link        <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      valid_out <= capture;
      redirect  <= capture & res_redirect;
      if (capture) begin
        is_cf       <= res_is_cf;
        taken       <= res_taken;
        target      <= res_target;
        link        <= pc_plus4;
        redirect_pc <= res_redirect_pc;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Branch history table
  // ---------------------------------------------------------------------
  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] lookup_idx;
  logic             unused_lookup_bits;

  assign upd_idx            = pc[IDX_W+1:2];
  assign lookup_idx         = lookup_pc[IDX_W+1:2];
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};
  // No bypass: a same-cycle update becomes visible after the clock edge.
  assign lookup_taken       = bht[lookup_idx][1];

  // Saturating counter training by captured conditional branches only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= BHT_INIT;
      end
    end else if (capture && is_br) begin
      if (br_cond) begin
        if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
      end else begin
        if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
      end
    end
  end

`ifdef BRU_STATS_EN
  // Event counters, updated on the same edge as the resolve outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cf      <= '0;
      stat_mispred <= '0;
    end else if (capture) begin
      stat_cf      <= stat_cf + 32'(res_is_cf);
      stat_mispred <= stat_mispred + 32'(res_redirect);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed cases plus randomized traffic
// against a reference model that works on instruction kinds and integer
// arithmetic. Expected results go into a queue; a monitor pops on valid_out.

module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int EXP_W = 99;

  // Instruction kinds used by the stimulus and the model.
  localparam int K_BEQ = 0, K_BNE = 1, K_BLT = 2, K_BGE = 3, K_BLTU = 4, K_BGEU = 5;
  localparam int K_JAL = 6, K_JALR = 7, K_NONE = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic            valid_in = 1'b0;
  logic [31:0]     instr = '0;
  logic [XLEN-1:0] pc = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            pred_taken_in = 1'b0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] lookup_pc = '0;
  logic            lookup_taken;
  logic            valid_out;
  logic            is_cf;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
`ifdef BRU_STATS_EN
  logic [31:0]     stat_cf;
  logic [31:0]     stat_mispred;
`endif

  branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .BHT_INIT(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .instr(instr), .pc(pc),
    .rs1(rs1), .rs2(rs2), .pred_taken_in(pred_taken_in), .flush(flush),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken), .valid_out(valid_out),
    .is_cf(is_cf), .taken(taken), .target(target), .link(link),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef BRU_STATS_EN
    , .stat_cf(stat_cf), .stat_mispred(stat_mispred)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [EXP_W-1:0] exp_q[$];  // {is_cf, taken, redirect, target, link, redirect_pc}
  int bht_m[DEPTH];
  int cnt_cf = 0;
  int cnt_mis = 0;
  int f3_tab[6] = '{0, 1, 4, 5, 6, 7};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) bht_m[i] = 1;
    cnt_cf = 0;
    cnt_mis = 0;
  endtask

  // ---------------- driver ----------------
  task automatic issue(input int kind, input int imm, input logic [31:0] ipc,
                       input logic [31:0] a, input logic [31:0] b, input logic pred,
                       input logic v, input logic fl, input logic [31:0] lpc);
    logic [31:0] ins;
    logic [12:0] bi;
    logic [20:0] ji;
    logic [11:0] ii;
    logic [2:0]  f3;
    logic        cf, tk, rd, exp_lk;
    logic [31:0] tgt, lnk, rpc;
    @(posedge clk);
    #1;
    bi = 13'(imm);
    ji = 21'(imm);
    ii = 12'(imm);
    ins = $urandom;
    if (kind <= K_BGEU) begin
      f3 = 3'(f3_tab[kind]);
      ins = {bi[12], bi[10:5], 5'd2, 5'd1, f3, bi[4:1], bi[11], 7'b1100011};
    end else if (kind == K_JAL) begin
      ins = {ji[20], ji[10:1], ji[11], ji[19:12], 5'd1, 7'b1101111};
    end else if (kind == K_JALR) begin
      ins = {ii, 5'd1, 3'b000, 5'd1, 7'b1100111};
    end else begin
      case (imm & 3)
        0:       begin ins[6:0] = 7'b1100011; ins[14:12] = 3'b010; end
        1:       begin ins[6:0] = 7'b1100011; ins[14:12] = 3'b011; end
        2:       begin ins[6:0] = 7'b1100111; ins[14:12] = 3'($urandom_range(1, 7)); end
        default: ins[6:0] = 7'b0110011;
      endcase
    end

    // Reference behaviour from the instruction semantics.
    cf = (kind != K_NONE);
    lnk = ipc + 32'd4;
    tk = 1'b0;
    rd = 1'b0;
    tgt = ipc + 32'(imm);
    rpc = 32'd0;
    case (kind)
      K_BEQ:  tk = (a == b);
      K_BNE:  tk = (a != b);
      K_BLT:  tk = ($signed(a) < $signed(b));
      K_BGE:  tk = !($signed(a) < $signed(b));
      K_BLTU: tk = (a < b);
      K_BGEU: tk = !(a < b);
      default: tk = (kind == K_JAL) || (kind == K_JALR);
    endcase
    if (kind <= K_BGEU) begin
      rd = (tk != pred);
      rpc = tk ? tgt : lnk;
    end else if (kind == K_JAL) begin
      rd = !pred;
      rpc = tgt;
    end else if (kind == K_JALR) begin
      tgt = (a + 32'(imm)) & 32'hFFFF_FFFE;
      rd = 1'b1;
      rpc = tgt;
    end

    exp_lk = (bht_m[lpc[7:2]] >= 2);
    valid_in = v;
    flush = fl;
    instr = ins;
    pc = ipc;
    rs1 = a;
    rs2 = b;
    pred_taken_in = pred;
    lookup_pc = lpc;

    if (v && !fl) begin
      exp_q.push_back({cf, tk, rd, tgt, lnk, rpc});
      cnt_cf += int'(cf);
      cnt_mis += int'(rd);
      if (kind <= K_BGEU) begin
        if (tk && bht_m[ipc[7:2]] < 3) bht_m[ipc[7:2]]++;
        else if (!tk && bht_m[ipc[7:2]] > 0) bht_m[ipc[7:2]]--;
      end
    end
    @(negedge clk);
    check("lookup_taken", {31'd0, lookup_taken}, {31'd0, exp_lk});
  endtask

  task automatic idle(input logic [31:0] lpc);
    issue(K_NONE, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, lpc);
  endtask

  function automatic logic [31:0] rand_opnd();
    logic [31:0] edges[5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic random_traffic(input int n);
    int kind, imm;
    logic [31:0] a, b, ipc, lpc;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 8);
      if (kind <= K_BGEU)     imm = int'($urandom_range(0, 4095)) * 2 - 4096;
      else if (kind == K_JAL) imm = int'($urandom_range(0, 1048575)) * 2 - 1048576;
      else if (kind == K_JALR) imm = int'($urandom_range(0, 4095)) - 2048;
      else                    imm = int'($urandom_range(0, 3));
      a = rand_opnd();
      b = ($urandom_range(0, 3) == 0) ? a : rand_opnd();
      ipc = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                         : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      lpc = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      issue(kind, imm, ipc, a, b, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 7) == 0), lpc);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid_out) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL unexpected_valid_out: got 1 expected 0 (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            check("is_cf", {31'd0, is_cf}, {31'd0, e[98]});
            check("taken", {31'd0, taken}, {31'd0, e[97]});
            check("redirect", {31'd0, redirect}, {31'd0, e[96]});
            check("link", link, e[63:32]);
            if (e[98]) check("target", target, e[95:64]);
            if (e[96]) check("redirect_pc", redirect_pc, e[31:0]);
          end
        end else begin
          check("redirect_idle", {31'd0, redirect}, 32'd0);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #10;
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_is_cf", {31'd0, is_cf}, 32'd0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_target", target, 32'd0);
    check("rst_link", link, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // BEQ taken, mispredicted; trains idx 0 from 1 to 2.
    issue(K_BEQ, 16, 32'h100, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0, 32'h100);
    // BLT signed vs BLTU unsigned on the same operands.
    issue(K_BLT, 8, 32'h200, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0, 32'h100);
    issue(K_BLTU, 8, 32'h204, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0, 32'h100);
    // Four taken BNE then two not-taken at 0x40, watching lookup each cycle.
    for (int i = 0; i < 4; i++)
      issue(K_BNE, -32, 32'h40, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0, 32'h40);
    for (int i = 0; i < 2; i++)
      issue(K_BNE, -32, 32'h40, 32'd3, 32'd3, 1'b0, 1'b1, 1'b0, 32'h40);
    idle(32'h40);
    // JALR with odd sum, then JAL predicted taken.
    issue(K_JALR, 4, 32'h80, 32'h2003, 32'd0, 1'b0, 1'b1, 1'b0, 32'h80);
    issue(K_JAL, 2048, 32'h84, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h80);
    // Flushed mispredicting BEQ, then a reserved-funct3 branch.
    issue(K_BEQ, 16, 32'h100, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1, 32'h100);
    issue(K_NONE, 0, 32'h300, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h100);
    idle(32'h100);

    random_traffic(400);
    idle(32'h0);
    idle(32'h0);
`ifdef BRU_STATS_EN
    check("stat_cf", stat_cf, 32'(cnt_cf));
    check("stat_mispred", stat_mispred, 32'(cnt_mis));
`endif

    // Train a few counters, then reset with an instruction in flight.
    for (int i = 0; i < 3; i++)
      issue(K_BEQ, 8, 32'h10 + 32'(i * 4), 32'd7, 32'd7, 1'b0, 1'b1, 1'b0, 32'h10);
    issue(K_JALR, 0, 32'h20, 32'h500, 32'd0, 1'b0, 1'b1, 1'b0, 32'h10);
    #2;
    rst_n = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("mid_rst_redirect", {31'd0, redirect}, 32'd0);
    check("mid_rst_is_cf", {31'd0, is_cf}, 32'd0);
    check("mid_rst_target", target, 32'd0);
    check("mid_rst_redirect_pc", redirect_pc, 32'd0);
`ifdef BRU_STATS_EN
    check("mid_rst_stat_cf", stat_cf, 32'd0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      lookup_pc = 32'(i * 4);
      #1;
      check("rst_lookup_taken", {31'd0, lookup_taken}, 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    random_traffic(100);
    idle(32'h0);
    idle(32'h0);
`ifdef BRU_STATS_EN
    check("stat_cf_end", stat_cf, 32'(cnt_cf));
    check("stat_mispred_end", stat_mispred, 32'(cnt_mis));
`endif
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised branch/jump resolution stage for the RV32I pipeline. Decodes B-type, JAL and JALR instructions and evaluates the condition. Computes target and link addresses, compares the outcome against the fetch-stage prediction, and issues a registered redirect. Holds a 2-bit saturating branch history table (BHT), read combinationally by fetch and trained by resolved conditional branches.

Parameters:
XLEN, 32, datapath/address width (32 or 64)
BHT_DEPTH, 64, BHT entries; power of two, >=2
BHT_INIT, 2'b01, counter reset value (weakly not-taken)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  instr/pc/operands valid this cycle
instr  in  32  instruction word
pc  in  XLEN  instruction address
rs1  in  XLEN  source operand 1
rs2  in  XLEN  source operand 2
pred_taken_in  in  1  direction predicted by fetch
flush  in  1  kill instruction presented this cycle
lookup_pc  in  XLEN  fetch-side BHT lookup address
lookup_taken  out  1  BHT prediction for lookup_pc (combinational)
valid_out  out  1  resolved result valid
is_cf  out  1  resolved instruction is a branch/jump
taken  out  1  actual direction
target  out  XLEN  actual taken target
link  out  XLEN  pc+4 (rd value for JAL/JALR)
redirect  out  1  mispredict, fetch must restart
redirect_pc  out  XLEN  restart address

Behaviour:
- Reset (rst_n=0, async): valid_out, is_cf, taken, redirect = 0; target, link, redirect_pc = 0; every BHT entry = BHT_INIT.
- Latency 1: inputs sampled at posedge clk, all resolve outputs registered. They update only on a capturing edge, otherwise hold. valid_out=0 marks outputs don't-care, but the outputs still hold defined values.
- Capture: valid_q <= valid_in & ~flush. flush wins over valid_in; a flushed slot causes no redirect and no BHT update.
- Decode: opcode 1100011 with funct3 000/001/100/101/110/111 = BEQ/BNE/BLT/BGE/BLTU/BGEU. opcode 1101111 = JAL, any funct3. opcode 1100111 with funct3 000 = JALR. Everything else, including branch funct3 010/011, is non-CF: is_cf=0, taken=0, redirect=0.
- Compare: BLT/BGE signed, BLTU/BGEU unsigned, on the full XLEN.
- Targets: B and J immediates sign-extended to XLEN. Branch/JAL target = pc+imm. JALR target = (rs1+I-imm) with bit0 cleared. link = pc+4. All sums are modulo 2^XLEN (wrap, no overflow flag).
- Redirect, conditional branch: redirect = taken ^ pred_taken_in. redirect_pc = taken ? target : pc+4.
- Redirect, JAL: redirect = ~pred_taken_in.
- Redirect, JALR: always redirect, because there is no target prediction. redirect_pc = target.
- BHT index = pc[log2(BHT_DEPTH)+1:2]; lookup uses the same slice of lookup_pc.
- BHT training: on a capturing edge with a valid conditional branch, the entry increments if taken (saturates at 3) or decrements if not taken (saturates at 0). JAL and JALR never train.
- lookup_taken = entry[1]. No bypass: a same-cycle update to the same index becomes visible on the next cycle.
- Reset mid-operation: in-flight result is dropped, no redirect emitted, BHT returns to BHT_INIT.

Optional Feature:
BRU_STATS_EN. When defined, adds ports stat_cf (out, 32) and stat_mispred (out, 32):
- stat_cf counts captured valid is_cf instructions; stat_mispred counts captured redirects.
- Both update on the same edge as the outputs and reset to 0.
- Both wrap at 2^32.
When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- BEQ at pc=0x100, imm=+16, rs1=rs2=5, pred=0 -> next cycle: valid_out=1, taken=1, target=0x110, redirect=1, redirect_pc=0x110; BHT[idx 0] 1->2.
- BLT rs1=0xFFFFFFFF, rs2=1, pred=1 -> taken=1, redirect=0. BLTU with the same operands and pred=1 -> taken=0, redirect=1, redirect_pc=pc+4.
- Four taken BNE at pc=0x40 -> lookup_pc=0x40 gives lookup_taken=1 after the 1st update, and the counter saturates at 3. Then two not-taken -> counter=1, lookup_taken=0.
- JALR rs1=0x2003, imm=+4, pc=0x80 -> target=0x2006, link=0x84, redirect=1, no BHT change. JAL with pred=1 -> redirect=0, link=pc+4.
- valid_in=1 with flush=1 on a mispredicting BEQ -> valid_out=0, redirect=0, BHT unchanged. funct3=010 branch opcode -> is_cf=0.
- rst_n low mid-stream after BHT training -> outputs 0 immediately (async), lookup_taken=0 for all indices. With BRU_STATS_EN: after 3 CF and 2 redirects, stat_cf=3, stat_mispred=2.
